// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pkg
//  Description : Shared constants, state encoding and angle helper for the
//                servo angle ramp block and its frame-tick sub-module.
//  Revision    : 1.0 - initial release
// ============================================================================
package servo_pkg;

    localparam int ANGLE_MAX            = 180;
    localparam int FRAME_CYCLES_DEFAULT = 240000;
    localparam int ANGLE_W              = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_e;

    // Limit a requested angle to the mechanical range 0..ANGLE_MAX.
    function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [ANGLE_W-1:0] a);
        logic [ANGLE_W-1:0] lim;
        lim = ANGLE_W'(ANGLE_MAX);
        return (a > lim) ? lim : a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_frame_tick.sv
`default_nettype none
// ============================================================================
//  Module      : servo_frame_tick
//  Description : Free-running frame counter; emits a registered one-cycle
//                tick each time the counter wraps. Shareable across joints.
//  Revision    : 1.0 - initial release
// ============================================================================
module servo_frame_tick
    import servo_pkg::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int                 c_CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(FRAME_CYCLES - 1);

    logic [c_CNT_W-1:0] r_count;
    logic               r_tick;

    // Count 0..FRAME_CYCLES-1 and pulse tick on the wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
            r_tick  <= 1'b1;
        end else begin
            r_count <= r_count + c_CNT_W'(1);
            r_tick  <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/servo_angle_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : servo_angle_ramp
//  Description : Accepts target-angle commands and slews angle_out toward the
//                target by at most STEP_DEG degrees per servo frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module servo_angle_ramp
    import servo_pkg::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEFAULT,
    parameter int STEP_DEG     = 2,
    parameter int INIT_ANGLE   = 90
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [ANGLE_W-1:0] cmd_angle,
    output logic               cmd_ready,
    output logic [ANGLE_W-1:0] angle_out,
    output logic               busy,
    output logic               done,
    output logic               frame_tick
);

    localparam logic [0:0]         c_ST_IDLE = IDLE;
    localparam logic [0:0]         c_ST_RAMP = RAMP;
    localparam logic [ANGLE_W-1:0] c_STEP    = ANGLE_W'(STEP_DEG);
    localparam logic [ANGLE_W-1:0] c_INIT    = ANGLE_W'(INIT_ANGLE);

    logic [0:0]         r_state;
    logic [ANGLE_W-1:0] r_angle;
    logic [ANGLE_W-1:0] r_target;
    logic               r_done;

    logic               w_tick;
    logic               w_accept;
    logic               w_up;
    logic [ANGLE_W-1:0] w_cmd_clamped;
    logic [ANGLE_W-1:0] w_dist;

    servo_frame_tick #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_frame_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_cmd_clamped = clamp_angle(cmd_angle);
    assign w_accept      = cmd_valid && (r_state == c_ST_IDLE);
    // Compare first, then subtract the smaller from the larger: no signed wrap.
    assign w_up          = (r_target >= r_angle);
    assign w_dist        = w_up ? (r_target - r_angle) : (r_angle - r_target);

    // Command acceptance, per-frame slewing and done pulse generation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_angle  <= c_INIT;
            r_target <= c_INIT;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // Frame ticks are deliberately ignored here, even one
                    // coinciding with acceptance.
                    if (w_accept) begin
                        r_target <= w_cmd_clamped;
                        if (w_cmd_clamped == r_angle) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= c_ST_RAMP;
                        end
                    end
                end
                c_ST_RAMP: begin
                    if (w_tick) begin
                        if (w_dist <= c_STEP) begin
                            // Final (possibly partial) step lands exactly on target.
                            r_angle <= r_target;
                            r_state <= c_ST_IDLE;
                            r_done  <= 1'b1;
                        end else if (w_up) begin
                            r_angle <= r_angle + c_STEP;
                        end else begin
                            r_angle <= r_angle - c_STEP;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = (r_state == c_ST_IDLE);
    assign busy       = (r_state == c_ST_RAMP);
    assign angle_out  = r_angle;
    assign done       = r_done;
    assign frame_tick = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_servo_angle_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_servo_angle_ramp
//  Description : Directed self-checking bench for servo_angle_ramp with a
//                100-cycle frame, 2-degree step and 90-degree start angle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_angle_ramp;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [7:0] cmd_angle;
    logic       cmd_ready;
    logic [7:0] angle_out;
    logic       busy;
    logic       done;
    logic       frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    servo_angle_ramp #(
        .FRAME_CYCLES (100),
        .STEP_DEG     (2),
        .INIT_ANGLE   (90)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_angle  (cmd_angle),
        .cmd_ready  (cmd_ready),
        .angle_out  (angle_out),
        .busy       (busy),
        .done       (done),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one command for a single cycle (block is idle when called).
    task automatic send(input logic [7:0] a);
        cmd_valid = 1'b1;
        cmd_angle = a;
        cyc();
        cmd_valid = 1'b0;
    endtask

    // Advance until frame_tick is visible (possibly already now).
    task automatic wait_tick();
        int n;
        n = 0;
        while (!frame_tick && n < 150) begin
            cyc();
            n++;
        end
        check("tick_seen", frame_tick, 1);
    endtask

    task automatic step_and_check(input string tag, input int exp_angle, input bit last);
        wait_tick();
        cyc();
        check({tag, "_angle"}, angle_out, exp_angle);
        check({tag, "_done"}, done, last);
        check({tag, "_busy"}, busy, !last);
    endtask

    // Run a ramp to completion, counting frames used and peak angle.
    task automatic run_ramp(input string tag, input int exp_frames, input int exp_final);
        int n;
        int frames;
        int maxa;
        n = 0;
        frames = 0;
        maxa = 0;
        while (!done && n < (exp_frames + 2) * 100) begin
            if (frame_tick) frames++;
            cyc();
            n++;
            if (int'(angle_out) > maxa) maxa = int'(angle_out);
        end
        check({tag, "_frames"}, frames, exp_frames);
        check({tag, "_final"}, angle_out, exp_final);
        check({tag, "_max_le_180"}, (maxa <= 180), 1);
    endtask

    initial begin
        int n;
        int viol;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_angle = 8'd0;

        // 1. reset state and frame timing
        repeat (3) cyc();
        check("rst_angle", angle_out, 90);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tick", frame_tick, 0);
        reset = 1'b0;
        n = 0;
        while (!frame_tick && n < 200) begin cyc(); n++; end
        check("first_tick_delay", n, 100);
        cyc();
        check("tick_one_cycle", frame_tick, 0);
        n = 1;
        while (!frame_tick && n < 200) begin cyc(); n++; end
        check("tick_period", n, 100);

        // 4. command equal to current angle
        send(8'd90);
        check("eq_done", done, 1);
        check("eq_busy", busy, 0);
        check("eq_angle", angle_out, 90);
        check("eq_ready", cmd_ready, 1);
        cyc();
        check("eq_done_clear", done, 0);
        check("eq_busy_after", busy, 0);

        // 2. basic ramp 90 -> 100
        send(8'd100);
        check("r100_busy", busy, 1);
        check("r100_ready", cmd_ready, 0);
        step_and_check("r100_s1", 92, 0);
        step_and_check("r100_s2", 94, 0);
        step_and_check("r100_s3", 96, 0);
        step_and_check("r100_s4", 98, 0);
        step_and_check("r100_s5", 100, 1);
        cyc();
        check("r100_done_clear", done, 0);
        check("r100_ready_after", cmd_ready, 1);

        // 5. command held during a ramp, then accepted on return to idle
        send(8'd110);
        cmd_valid = 1'b1;
        cmd_angle = 8'd50;
        viol = 0;
        n = 0;
        while (!done && n < 700) begin
            if (cmd_ready !== 1'b0) viol++;
            cyc();
            n++;
        end
        check("hold_ready_low", viol, 0);
        check("hold_done", done, 1);
        check("hold_angle", angle_out, 110);
        check("hold_ready_idle", cmd_ready, 1);
        cyc();
        cmd_valid = 1'b0;
        check("hold_accepted_busy", busy, 1);
        check("hold_accepted_done", done, 0);
        check("hold_accepted_angle", angle_out, 110);
        run_ramp("r50", 30, 50);

        // 5b. acceptance coinciding with frame_tick takes no step that frame
        wait_tick();
        send(8'd60);
        check("coinc_angle", angle_out, 50);
        check("coinc_busy", busy, 1);
        n = 0;
        while (angle_out == 8'd50 && n < 300) begin cyc(); n++; end
        check("coinc_first_step_delay", n, 100);
        check("coinc_first_step", angle_out, 52);
        run_ramp("r60", 4, 60);

        // 6. reset mid-ramp at 130
        send(8'd140);
        n = 0;
        while (angle_out != 8'd130 && n < 40) begin
            wait_tick();
            cyc();
            n++;
        end
        check("mid_reach_130", angle_out, 130);
        reset = 1'b1;
        cyc();
        check("mid_rst_angle", angle_out, 90);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_tick", frame_tick, 0);
        reset = 1'b0;
        n = 0;
        while (!frame_tick && n < 200) begin
            if (done) viol++;
            cyc();
            n++;
        end
        check("mid_rst_tick_delay", n, 100);

        // 3. clamp 200 -> 180, then 175 with partial last step
        send(8'd200);
        check("clamp_busy", busy, 1);
        run_ramp("clamp", 45, 180);
        cyc();
        send(8'd175);
        step_and_check("p175_s1", 178, 0);
        step_and_check("p175_s2", 176, 0);
        step_and_check("p175_s3", 175, 1);
        cyc();
        check("p175_done_clear", done, 0);
        check("p175_ready", cmd_ready, 1);
        check("no_done_during_reset", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
